rolha_refill_scheduler: RTL

Controller that moves corks (rolhas) from the warehouse stock into the sealing dispenser in timed batches. It also arbitrates dispenser access between the sealing FSM, which consumes one cork per seal, and the refill transfer, which adds one cork per cycle. It sits between the stock/operator inputs and the vedação FSM, and replaces the ad-hoc load/up-down counter pair around the dispenser.

---
 rtl/rolha_pkg.sv | 18 +
 rtl/rolha_refill_scheduler_if.sv | 27 ++
 rtl/contador_sat.sv | 34 +++
 rtl/rolha_refill_scheduler.sv | 129 ++++++++++++
 4 files changed

// File: rtl/rolha_pkg.sv
// Shared types and default sizing for the cork refill scheduler.
package rolha_pkg;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned LOW_MARK = 5;
    localparam int unsigned BATCH    = 15;
    localparam int unsigned DISP_CAP = 24;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        XFER,
        DONE
    } state_t;

endpackage

// File: rtl/rolha_refill_scheduler_if.sv
// Stock/operator inputs and dispenser status outputs of the refill scheduler.
interface rolha_refill_scheduler_if;
    import rolha_pkg::*;

    logic load_stock;
    cnt_t stock_in;
    logic add_stock;
    logic consume;
    cnt_t disp_count;
    cnt_t stock;
    logic rolha;
    logic refill_busy;
    logic refill_done;
    logic stock_empty;
    logic underflow;

    modport master (
        output load_stock, stock_in, add_stock, consume,
        input  disp_count, stock, rolha, refill_busy, refill_done, stock_empty, underflow
    );

    modport slave (
        input  load_stock, stock_in, add_stock, consume,
        output disp_count, stock, rolha, refill_busy, refill_done, stock_empty, underflow
    );

endinterface

// File: rtl/contador_sat.sv
// 8-bit saturating up/down counter with synchronous load; inc and dec together hold.
module contador_sat
    import rolha_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  cnt_t load_val,
    input  logic inc,
    input  logic dec,
    output cnt_t q,
    output cnt_t next_c
);

    always_comb begin
        next_c = q;
        if (load) begin
            next_c = load_val;
        end else if (inc && !dec && (q != '1)) begin
            next_c = q + CNT_W'(1);
        end else if (dec && !inc && (q != '0)) begin
            next_c = q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= next_c;
        end
    end

endmodule

// File: rtl/rolha_refill_scheduler.sv
// Moves corks from warehouse stock into the dispenser in batches and
// arbitrates dispenser updates between refill transfers and seal consumption.
module rolha_refill_scheduler #(
    parameter int unsigned LOW_MARK = rolha_pkg::LOW_MARK,
    parameter int unsigned BATCH    = rolha_pkg::BATCH,
    parameter int unsigned DISP_CAP = rolha_pkg::DISP_CAP
) (
    input logic                     clk,
    input logic                     reset,
    rolha_refill_scheduler_if.slave bus
);
    import rolha_pkg::*;

    state_t state;
    state_t state_next;
    cnt_t   remaining;
    cnt_t   remaining_next;
    cnt_t   disp_q;
    cnt_t   disp_next_c;
    cnt_t   stock_q;
    cnt_t   stock_next_c;
    cnt_t   room;
    cnt_t   batch;
    logic   xfer;
    logic   trigger;
    logic   disp_dec;
    logic   stock_load;
    logic   underflow_evt;
    logic   busy_next;

    function automatic cnt_t min3(cnt_t a, cnt_t b, cnt_t c);
        cnt_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Room is safe in 8 bits because disp_count never exceeds DISP_CAP.
    assign xfer          = (state == XFER);
    assign room          = CNT_W'(DISP_CAP) - disp_q;
    assign batch         = min3(CNT_W'(BATCH), stock_q, room);
    assign trigger       = (disp_q <= CNT_W'(LOW_MARK)) && (stock_q != '0) && !bus.load_stock;
    assign disp_dec      = bus.consume && ((disp_q != '0) || xfer);
    assign underflow_evt = bus.consume && (disp_q == '0) && !xfer;
    assign stock_load    = bus.load_stock && (state == IDLE);

    contador_sat u_disp (
        .clk      (clk),
        .rst_n    (reset),
        .load     (1'b0),
        .load_val ('0),
        .inc      (xfer),
        .dec      (disp_dec),
        .q        (disp_q),
        .next_c   (disp_next_c)
    );

    // A transfer cycle decrements stock; a coincident add_stock cancels it.
    contador_sat u_stock (
        .clk      (clk),
        .rst_n    (reset),
        .load     (stock_load),
        .load_val (bus.stock_in),
        .inc      (bus.add_stock),
        .dec      (xfer),
        .q        (stock_q),
        .next_c   (stock_next_c)
    );

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                remaining_next = batch;
                state_next     = (batch == '0) ? DONE : XFER;
            end
            XFER: begin
                remaining_next = (remaining != '0) ? remaining - CNT_W'(1) : '0;
                if (remaining <= CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_next = (state_next == CALC) || (state_next == XFER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Status flags are registered from next-state values so they line up with the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rolha       <= 1'b0;
            bus.stock_empty <= 1'b1;
            bus.refill_busy <= 1'b0;
            bus.refill_done <= 1'b0;
            bus.underflow   <= 1'b0;
        end else begin
            bus.rolha       <= (disp_next_c != '0);
            bus.stock_empty <= (stock_next_c == '0);
            bus.refill_busy <= busy_next;
            bus.refill_done <= (state == DONE);
            bus.underflow   <= underflow_evt;
        end
    end

    assign bus.disp_count = disp_q;
    assign bus.stock      = stock_q;

endmodule
